// File: rtl/shift_seq_ctrl.sv
// Upstream sequencer for an (N+1)-bit bidirectional shift register. It takes a parallel
// word over valid/ready, streams it out serially, then pulses done for one cycle.
module shift_seq_ctrl #(
  parameter int N = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [N:0]   load_data,
  input  logic         load_dir,
  input  logic         abort,
  output logic         shift_en,
  output logic         dir,
  output logic         d_in,
  output logic         busy,
  output logic         done,
  output logic [1:0]   fsm_state
);

  // Handshake: a word is taken on a rising edge where load_valid && load_ready are both
  // high. load_ready is high only in IDLE. While load_valid is high and load_ready is low,
  // upstream holds load_data and load_dir steady. load_valid does not depend on load_ready.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int CW = $clog2(N + 2);
  localparam logic [CW-1:0] LAST = CW'(N);

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [N:0]    word, word_nxt;
  logic          dir_nxt;
  logic          load_ready_nxt, shift_en_nxt, d_in_nxt, busy_nxt, done_nxt;
  logic [CW-1:0] bit_idx;
  logic          bit_sel;

  // Outputs are registered from next-state values, so the shift register sees each
  // bit on the edge right after it is launched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      word       <= '0;
      dir        <= 1'b0;
      load_ready <= 1'b1;
      shift_en   <= 1'b0;
      d_in       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      word       <= word_nxt;
      dir        <= dir_nxt;
      load_ready <= load_ready_nxt;
      shift_en   <= shift_en_nxt;
      d_in       <= d_in_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    count_nxt = count;
    word_nxt  = word;
    dir_nxt   = dir;
    unique case (state)
      IDLE: begin
        if (load_valid) begin
          state_nxt = SHIFT;
          count_nxt = '0;
          word_nxt  = load_data;
          dir_nxt   = load_dir;
        end
      end
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (count == LAST) begin
          state_nxt = DONE;
        end else begin
          count_nxt = count + 1'b1;
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Left shifts send the MSB first, right shifts the LSB first.
  always_comb begin
    bit_idx = dir_nxt ? count_nxt : (LAST - count_nxt);
    bit_sel = 1'b0;
    for (int i = 0; i <= N; i++) begin
      if (bit_idx == i[CW-1:0]) bit_sel = word_nxt[i];
    end
    load_ready_nxt = (state_nxt == IDLE);
    shift_en_nxt   = (state_nxt == SHIFT);
    busy_nxt       = (state_nxt != IDLE);
    done_nxt       = (state_nxt == DONE);
    d_in_nxt       = (state_nxt == SHIFT) ? bit_sel : 1'b0;
  end

  assign fsm_state = state;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: a behavioural shift register downstream,
// hand-computed expected words and cycle timings.
module tb_shift_seq_ctrl;

  localparam int N = 15;
  localparam int W = N + 1;

  logic         clk;
  logic         rst_n;
  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_data;
  logic         load_dir;
  logic         abort;
  logic         shift_en;
  logic         dir;
  logic         d_in;
  logic         busy;
  logic         done;
  logic [1:0]   fsm_state;

  int tests_run = 0;
  int tests_failed = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  shift_seq_ctrl #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dir   (load_dir),
    .abort      (abort),
    .shift_en   (shift_en),
    .dir        (dir),
    .d_in       (d_in),
    .busy       (busy),
    .done       (done),
    .fsm_state  (fsm_state)
  );

  // ---------------- downstream shift register and monitor ----------------
  logic [W-1:0] q_model;
  logic [W-1:0] bits_seen;
  logic [W-1:0] exp_q[$];
  int shift_cnt, done_cnt, gap_cnt, last_gap;

  initial begin
    q_model = '0; bits_seen = '0; shift_cnt = 0; done_cnt = 0; gap_cnt = 0; last_gap = 0;
  end

  always @(posedge clk) begin
    if (shift_en) begin
      if (dir) q_model = {d_in, q_model[W-1:1]};
      else     q_model = {q_model[W-2:0], d_in};
      bits_seen = {bits_seen[W-2:0], d_in};
      shift_cnt++;
      if (gap_cnt > 0) last_gap = gap_cnt;
      gap_cnt = 0;
    end else begin
      gap_cnt++;
    end
    if (done) begin
      done_cnt++;
      exp_q.push_back(q_model);
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    q_model = '0;
    bits_seen = '0;
    shift_cnt = 0;
    done_cnt = 0;
    exp_q.delete();
  endtask

  task automatic check_snap(input string tag, input logic [W-1:0] exp);
    if (exp_q.size() == 0) check({tag, "_missing"}, 32'd0, 32'd1);
    else check(tag, exp_q.pop_front(), exp);
  endtask

  // ---------------- drivers ----------------
  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic do_load(input logic [W-1:0] w, input logic d, output int waited);
    load_data  = w;
    load_dir   = d;
    load_valid = 1'b1;
    waited     = 0;
    forever begin
      @(posedge clk);
      waited++;
      if (load_ready) break;
      if (waited > 100) begin
        check("load_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(negedge clk);
  endtask

  // Starts at the first negedge after acceptance (cycle 1).
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  int w1, w2, lat;

  initial begin
    rst_n = 1'b0; load_valid = 1'b0; load_data = '0; load_dir = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_load_ready", load_ready, 1);
    check("rst_shift_en", shift_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_d_in", d_in, 0);
    check("rst_dir", dir, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", load_ready, 1);

    // 1: A5C3 left, MSB first
    clear_model();
    do_load(16'hA5C3, 1'b0, w1);
    load_valid = 1'b0;
    check("t1_busy", busy, 1);
    check("t1_ready_low", load_ready, 0);
    check("t1_first_bit", d_in, 1);
    wait_done(lat);
    check("t1_done_lat", lat, 17);
    check("t1_shifts", shift_cnt, 16);
    check("t1_bits", bits_seen, 16'hA5C3);
    check("t1_q", q_model, 16'hA5C3);
    @(negedge clk);
    check("t1_done_once", done, 0);
    check("t1_ready_back", load_ready, 1);
    check("t1_busy_low", busy, 0);
    check("t1_done_cnt", done_cnt, 1);

    // 2: A5C3 right, LSB first
    clear_model();
    do_load(16'hA5C3, 1'b1, w1);
    load_valid = 1'b0;
    check("t2_dir", dir, 1);
    check("t2_first_bit", d_in, 1);
    wait_done(lat);
    check("t2_done_lat", lat, 17);
    check("t2_bits", bits_seen, 16'hC3A5);
    check("t2_q", q_model, 16'hA5C3);
    @(negedge clk);
    check("t2_done_cnt", done_cnt, 1);
    check("t2_dir_hold", dir, 1);

    // 3: FFFF held valid while 0001 in flight
    clear_model();
    do_load(16'h0001, 1'b0, w1);
    load_data = 16'hFFFF;
    do_load(16'hFFFF, 1'b0, w2);
    load_valid = 1'b0;
    check("t3_second_wait", w2, 18);
    wait_done(lat);
    @(negedge clk);
    check_snap("t3_first_word", 16'h0001);
    check_snap("t3_second_word", 16'hFFFF);
    check("t3_gap", last_gap, 2);

    // 4: abort on the 5th SHIFT cycle
    clear_model();
    do_load(16'hFFFF, 1'b0, w1);
    load_valid = 1'b0;
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_shift_en", shift_en, 0);
    check("t4_ready", load_ready, 1);
    check("t4_busy", busy, 0);
    check("t4_d_in", d_in, 0);
    check("t4_shifts", shift_cnt, 5);
    check("t4_q_partial", q_model, 16'h001F);
    repeat (20) @(negedge clk);
    check("t4_no_done", done_cnt, 0);

    // abort together with load in IDLE: load wins
    clear_model();
    abort = 1'b1;
    do_load(16'h00FF, 1'b1, w1);
    abort = 1'b0;
    load_valid = 1'b0;
    check("t4b_accept_wait", w1, 1);
    check("t4b_busy", busy, 1);
    wait_done(lat);
    check("t4b_done_lat", lat, 17);
    check("t4b_q", q_model, 16'h00FF);
    @(negedge clk);

    // 5: reset on the 8th SHIFT cycle
    clear_model();
    do_load(16'hA5C3, 1'b1, w1);
    load_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t5_shift_en", shift_en, 0);
    check("t5_dir", dir, 0);
    check("t5_d_in", d_in, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_ready", load_ready, 1);
    check("t5_state", fsm_state, 0);
    check("t5_shifts", shift_cnt, 8);
    rst_n = 1'b1;
    @(negedge clk);
    clear_model();
    do_load(16'hA5C3, 1'b0, w1);
    load_valid = 1'b0;
    wait_done(lat);
    check("t5_rerun_lat", lat, 17);
    check("t5_rerun_shifts", shift_cnt, 16);
    check("t5_rerun_q", q_model, 16'hA5C3);
    @(negedge clk);

    // 6: back-to-back 1234 then 8001
    clear_model();
    do_load(16'h1234, 1'b0, w1);
    load_data = 16'h8001;
    do_load(16'h8001, 1'b0, w2);
    load_valid = 1'b0;
    check("t6_second_wait", w2, 18);
    wait_done(lat);
    @(negedge clk);
    check("t6_gap", last_gap, 2);
    check("t6_done_cnt", done_cnt, 2);
    check_snap("t6_first_word", 16'h1234);
    check_snap("t6_second_word", 16'h8001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
